// File: rtl/gcd_pkg.sv
// gcd_pkg -- definitions shared by the GCD requester and the GCD controller.
//   GCD_WIDTH   : default operand/result width
//   gcd_state_e : 3-bit requester state encoding
//   gcd_fn_e    : function codes understood by the GCD controller
//   is_wait     : true for states where the wait counter runs
package gcd_pkg;

    localparam int GCD_WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND_A = 3'd1,
        ST_REL_A  = 3'd2,
        ST_SEND_B = 3'd3,
        ST_REL_B  = 3'd4,
        ST_FLUSH  = 3'd5
    } gcd_state_e;

    typedef enum logic [1:0] {
        FN_NOP    = 2'd0,
        FN_LOAD_A = 2'd1,
        FN_LOAD_B = 2'd2,
        FN_RESULT = 2'd3
    } gcd_fn_e;

    // FLUSH also waits (for ack to drop), so it is timed like the handshake states.
    function automatic logic is_wait(input gcd_state_e s);
        return (s == ST_SEND_A) || (s == ST_REL_A) || (s == ST_SEND_B) ||
               (s == ST_REL_B)  || (s == ST_FLUSH);
    endfunction

endpackage

// File: rtl/hs_timer.sv
// hs_timer -- clearable saturating wait counter for handshake states.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   clr_i : clear the count (state change)
//   en_i  : count this cycle
//   hit_o : high during the TIMEOUT-th consecutive enabled cycle
// The count holds the number of cycles already spent in the state, so
// hit_o flags the cycle in which that number reaches TIMEOUT.
module hs_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/gcd_requester.sv
// gcd_requester -- sends two operands to a GCD unit over a 4-phase req/ack
// handshake and returns the result.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   start          : request a job (IDLE only), a_in/b_in sampled with it
//   req, data_out  : 4-phase request and operand bus to the GCD unit
//   ack, result_in : acknowledge and result bus from the GCD unit
//   busy           : high whenever not IDLE
//   done, err      : one-cycle completion / rejection-or-abort pulses
//   result         : last captured GCD
// All outputs are flops loaded with the value belonging to the next state.
module gcd_requester
    import gcd_pkg::*;
#(
    parameter int WIDTH   = GCD_WIDTH,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             req,
    input  logic             ack,
    output logic [WIDTH-1:0] data_out,
    input  logic [WIDTH-1:0] result_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    gcd_state_e       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             req_q, req_d, busy_q, busy_d;
    logic             done_q, done_d, err_q, err_d;
    logic             tmo;
    logic             start_ok;

    // A zero operand would never terminate in the GCD unit, so reject it.
    assign start_ok = start && (a_in != '0) && (b_in != '0);

    hs_timer #(
        .TIMEOUT(TIMEOUT)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (state_d != state_q),
        .en_i  (is_wait(state_q)),
        .hit_o (tmo)
    );

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            data_q   <= '0;
            req_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            data_q   <= data_d;
            req_q    <= req_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    // Next state: a handshake edge is checked before the timeout, so an ack
    // arriving on the last allowed cycle still completes the phase.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_ok) state_d = ST_SEND_A;
            ST_SEND_A: if (ack)      state_d = ST_REL_A;
                       else if (tmo) state_d = ST_FLUSH;
            ST_REL_A:  if (!ack)     state_d = ST_SEND_B;
                       else if (tmo) state_d = ST_FLUSH;
            ST_SEND_B: if (ack)      state_d = ST_REL_B;
                       else if (tmo) state_d = ST_FLUSH;
            ST_REL_B:  if (!ack)     state_d = ST_IDLE;
                       else if (tmo) state_d = ST_FLUSH;
            ST_FLUSH:  if (!ack || tmo) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output / datapath next values
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
        if ((state_q == ST_IDLE) && start_ok) begin
            a_d = a_in;
            b_d = b_in;
        end
        if ((state_q == ST_SEND_B) && ack) begin
            result_d = result_in;
        end

        req_d  = (state_d == ST_SEND_A) || (state_d == ST_SEND_B);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_q == ST_REL_B) && !ack;
        err_d  = ((state_q == ST_IDLE) && start && !start_ok) ||
                 ((state_q == ST_FLUSH) && (!ack || tmo));

        // a_d rather than a_q so the freshly latched operand appears on entry.
        unique case (state_d)
            ST_SEND_A, ST_REL_A: data_d = a_d;
            ST_SEND_B, ST_REL_B: data_d = b_q;
            ST_FLUSH:            data_d = data_q;
            default:             data_d = '0;
        endcase
    end

    assign req      = req_q;
    assign data_out = data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign result   = result_q;

endmodule

// File: tb/tb_gcd_requester.sv
// tb_gcd_requester -- self-checking bench for gcd_requester with a
// behavioural 4-phase GCD unit whose per-phase response delay is programmable.
module tb_gcd_requester;

    localparam int W   = 8;
    localparam int TMO = 10;

    logic         clk = 1'b0;
    logic         rst_n, start, req, ack, busy, done, err;
    logic [W-1:0] a_in, b_in, data_out, result_in, result;

    gcd_requester #(.WIDTH(W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a_in(a_in), .b_in(b_in),
        .req(req), .ack(ack), .data_out(data_out), .result_in(result_in),
        .busy(busy), .done(done), .result(result), .err(err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int dly[4];                 // GCD unit response delay per phase, -1 = random 0..3
    logic [W-1:0] a_seen, b_seen;
    logic [W-1:0] last_res;

    int ack_edges = 0, done_hi = 0, err_hi = 0, busy_hi = 0, req_rise = 0;
    int stab_viol = 0, idle_viol = 0, overlap = 0;

    function automatic logic [W-1:0] ref_gcd(input logic [W-1:0] x, input logic [W-1:0] y);
        int p, q, t;
        p = int'(x);
        q = int'(y);
        while (q != 0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return W'(p);
    endfunction

    // Behavioural GCD unit: phase 0 wait req=1, 1 wait req=0, 2 wait req=1, 3 wait req=0.
    initial begin : gcd_unit
        int sph, cnt, cur;
        logic cond;
        sph = 0; cnt = 0; cur = 0;
        ack = 1'b0;
        result_in = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                ack = 1'b0; sph = 0; cnt = 0;
            end else begin
                cond = (sph % 2 == 0) ? req : !req;
                if (!cond) begin
                    cnt = 0;
                end else begin
                    if (cnt == 0) cur = (dly[sph] < 0) ? int'($urandom_range(0, 3)) : dly[sph];
                    if (cnt >= cur) begin
                        case (sph)
                            0: begin a_seen = data_out; ack = 1'b1; end
                            1: ack = 1'b0;
                            2: begin
                                b_seen = data_out;
                                result_in = ref_gcd(a_seen, data_out);
                                ack = 1'b1;
                            end
                            default: begin ack = 1'b0; result_in = W'($urandom); end
                        endcase
                        sph = (sph + 1) % 4;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // Protocol observer, sampling shortly after each rising edge.
    initial begin : observer
        logic pa, preq;
        logic [W-1:0] pdata;
        pa = 1'b0; preq = 1'b0; pdata = '0;
        forever begin
            @(posedge clk);
            #2;
            if (ack !== pa) ack_edges++;
            if (done === 1'b1) done_hi++;
            if (err === 1'b1) err_hi++;
            if (busy === 1'b1) busy_hi++;
            if (req && !preq) req_rise++;
            if (req && preq && data_out !== pdata) stab_viol++;
            if (preq && !req && busy && data_out !== pdata) stab_viol++;
            if (!busy && data_out !== '0) idle_viol++;
            if (done && err) overlap++;
            pa = ack; preq = req; pdata = data_out;
        end
    end

    task automatic set_dly(input int d0, input int d1, input int d2, input int d3);
        dly[0] = d0; dly[1] = d1; dly[2] = d2; dly[3] = d3;
    endtask

    // Leaves the caller at the falling edge after the start-sampling edge.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        start = 1'b1; a_in = a; b_in = b;
        @(negedge clk);
        start = 1'b0; a_in = W'($urandom); b_in = W'($urandom);
    endtask

    task automatic wait_end(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (done || err) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        start = 1'b0; a_in = '0; b_in = '0; rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", req); end
        n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data: got %0d want 0", data_out); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
        n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
        n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL reset_result: got %0d want 0", result); end
        #1 rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int ae, d0, e0;
        bit ok;
        set_dly(0, 0, 0, 0);
        ae = ack_edges; d0 = done_hi; e0 = err_hi;
        launch(8'd12, 8'd18);
        wait_end(50, ok);
        @(negedge clk);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL basic_end: got %b want 1", ok); end
        n_cmp++; if (result !== 8'd6) begin n_bad++; $display("FAIL basic_result: got %0d want 6", result); end
        n_cmp++; if (done_hi - d0 != 1) begin n_bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_hi - d0); end
        n_cmp++; if (err_hi - e0 != 0) begin n_bad++; $display("FAIL basic_err_cnt: got %0d want 0", err_hi - e0); end
        n_cmp++; if (ack_edges - ae != 4) begin n_bad++; $display("FAIL basic_ack_edges: got %0d want 4", ack_edges - ae); end
        n_cmp++; if (a_seen !== 8'd12 || b_seen !== 8'd18) begin
            n_bad++; $display("FAIL basic_operands: got %0d,%0d want 12,18", a_seen, b_seen);
        end
        last_res = 8'd6;
    endtask

    task automatic test_zero();
        int e0, b0, r0;
        e0 = err_hi; b0 = busy_hi; r0 = req_rise;
        launch(8'd0, 8'd7);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL zero_a_err: got %b want 1", err); end
        repeat (3) @(negedge clk);
        launch(8'd5, 8'd0);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL zero_b_err: got %b want 1", err); end
        repeat (3) @(negedge clk);
        n_cmp++; if (err_hi - e0 != 2) begin n_bad++; $display("FAIL zero_err_cnt: got %0d want 2", err_hi - e0); end
        n_cmp++; if (busy_hi - b0 != 0) begin n_bad++; $display("FAIL zero_busy: got %0d want 0", busy_hi - b0); end
        n_cmp++; if (req_rise - r0 != 0) begin n_bad++; $display("FAIL zero_req: got %0d want 0", req_rise - r0); end
        n_cmp++; if (result !== last_res) begin n_bad++; $display("FAIL zero_result: got %0d want %0d", result, last_res); end
    endtask

    task automatic test_timeout();
        int d0, req_cnt, err_at;
        logic flush_busy, flush_req;
        set_dly(1000, 0, 0, 0);
        d0 = done_hi; req_cnt = 0; err_at = -1;
        flush_busy = 1'b0; flush_req = 1'b1;
        launch(8'd5, 8'd3);
        for (int i = 1; i <= 30; i++) begin
            if (req) req_cnt++;
            if (i == 11) begin flush_busy = busy; flush_req = req; end
            if (err) begin err_at = i; break; end
            @(negedge clk);
        end
        n_cmp++; if (req_cnt != TMO) begin n_bad++; $display("FAIL tmo_req_cycles: got %0d want %0d", req_cnt, TMO); end
        n_cmp++; if (flush_busy !== 1'b1 || flush_req !== 1'b0) begin
            n_bad++; $display("FAIL tmo_flush: got busy=%b req=%b want busy=1 req=0", flush_busy, flush_req);
        end
        n_cmp++; if (err_at != TMO + 2) begin n_bad++; $display("FAIL tmo_err_cycle: got %0d want %0d", err_at, TMO + 2); end
        @(negedge clk);
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL tmo_idle: got busy=%b want 0", busy); end
        n_cmp++; if (result !== last_res) begin n_bad++; $display("FAIL tmo_result: got %0d want %0d", result, last_res); end
        n_cmp++; if (done_hi - d0 != 0) begin n_bad++; $display("FAIL tmo_done: got %0d want 0", done_hi - d0); end
        set_dly(0, 0, 0, 0);
    endtask

    task automatic test_ignore_start();
        int d0, r0;
        bit found, ok;
        set_dly(0, 0, 4, 0);
        d0 = done_hi; found = 1'b0;
        launch(8'd35, 8'd21);
        for (int i = 0; i < 30; i++) begin
            if (req && data_out == 8'd21) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL ign_send_b: got %b want 1", found); end
        start = 1'b1; a_in = 8'd2; b_in = 8'd4;
        @(negedge clk);
        start = 1'b0;
        wait_end(50, ok);
        @(negedge clk);
        n_cmp++; if (result !== 8'd7) begin n_bad++; $display("FAIL ign_result: got %0d want 7", result); end
        r0 = req_rise;
        repeat (6) @(negedge clk);
        n_cmp++; if (done_hi - d0 != 1) begin n_bad++; $display("FAIL ign_done_cnt: got %0d want 1", done_hi - d0); end
        n_cmp++; if (req_rise - r0 != 0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL ign_queued: got req_rises=%0d busy=%b want 0,0", req_rise - r0, busy);
        end
        last_res = 8'd7;
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        bit found, ok;
        set_dly(0, 5, 0, 0);
        found = 1'b0;
        launch(8'd40, 8'd30);
        for (int i = 0; i < 20; i++) begin
            if (busy && !req) begin found = 1'b1; break; end
            @(negedge clk);
        end
        n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL rst_rel_a: got %b want 1", found); end
        d0 = done_hi; e0 = err_hi;
        #1 rst_n = 1'b0;
        #1;
        n_cmp++; if (req !== 1'b0 || busy !== 1'b0 || data_out !== '0) begin
            n_bad++; $display("FAIL rst_async: got req=%b busy=%b data=%0d want 0,0,0", req, busy, data_out);
        end
        repeat (3) @(negedge clk);
        n_cmp++; if (done_hi - d0 != 0 || err_hi - e0 != 0) begin
            n_bad++; $display("FAIL rst_pulses: got done=%0d err=%0d want 0,0", done_hi - d0, err_hi - e0);
        end
        n_cmp++; if (result !== '0) begin n_bad++; $display("FAIL rst_result: got %0d want 0", result); end
        set_dly(0, 0, 0, 0);
        #1 rst_n = 1'b1;
        start = 1'b1; a_in = 8'd9; b_in = 8'd6;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (busy !== 1'b1 || req !== 1'b1 || data_out !== 8'd9) begin
            n_bad++; $display("FAIL rst_first_start: got busy=%b req=%b data=%0d want 1,1,9", busy, req, data_out);
        end
        wait_end(50, ok);
        @(negedge clk);
        n_cmp++; if (ok !== 1'b1 || result !== 8'd3) begin
            n_bad++; $display("FAIL rst_next_job: got end=%b result=%0d want 1,3", ok, result);
        end
        last_res = 8'd3;
    endtask

    task automatic test_timeout_race();
        int d0, e0, req_cnt;
        set_dly(0, 0, TMO - 1, 0);
        d0 = done_hi; e0 = err_hi; req_cnt = 0;
        launch(8'd20, 8'd8);
        for (int i = 0; i < 80; i++) begin
            if (req) req_cnt++;
            if (done || err) break;
            @(negedge clk);
        end
        @(negedge clk);
        n_cmp++; if (req_cnt != TMO + 1) begin n_bad++; $display("FAIL race_req_cycles: got %0d want %0d", req_cnt, TMO + 1); end
        n_cmp++; if (err_hi - e0 != 0) begin n_bad++; $display("FAIL race_err: got %0d want 0", err_hi - e0); end
        n_cmp++; if (done_hi - d0 != 1) begin n_bad++; $display("FAIL race_done: got %0d want 1", done_hi - d0); end
        n_cmp++; if (result !== 8'd4) begin n_bad++; $display("FAIL race_result: got %0d want 4", result); end
        set_dly(0, 0, 0, 0);
        last_res = 8'd4;
    endtask

    task automatic test_random();
        logic [W-1:0] ta[4] = '{8'd255, 8'd1, 8'd128, 8'd17};
        logic [W-1:0] tb[4] = '{8'd255, 8'd255, 8'd96, 8'd13};
        logic [W-1:0] a, b, g;
        int ae, d0;
        bit ok;
        set_dly(-1, -1, -1, -1);
        for (int j = 0; j < 20; j++) begin
            if (j < 4) begin
                a = ta[j]; b = tb[j];
            end else begin
                a = W'($urandom_range(1, 255)); b = W'($urandom_range(1, 255));
            end
            g = ref_gcd(a, b);
            ae = ack_edges; d0 = done_hi;
            launch(a, b);
            wait_end(60, ok);
            @(negedge clk);
            n_cmp++; if (ok !== 1'b1 || result !== g) begin
                n_bad++; $display("FAIL rand_result[%0d]: got end=%b result=%0d want 1,%0d (a=%0d b=%0d)", j, ok, result, g, a, b);
            end
            n_cmp++; if (ack_edges - ae != 4 || done_hi - d0 != 1) begin
                n_bad++; $display("FAIL rand_proto[%0d]: got edges=%0d dones=%0d want 4,1", j, ack_edges - ae, done_hi - d0);
            end
            n_cmp++; if (a_seen !== a || b_seen !== b) begin
                n_bad++; $display("FAIL rand_operands[%0d]: got %0d,%0d want %0d,%0d", j, a_seen, b_seen, a, b);
            end
        end
        set_dly(0, 0, 0, 0);
    endtask

    task automatic test_invariants();
        n_cmp++; if (stab_viol != 0) begin n_bad++; $display("FAIL inv_data_stable: got %0d want 0", stab_viol); end
        n_cmp++; if (idle_viol != 0) begin n_bad++; $display("FAIL inv_idle_data: got %0d want 0", idle_viol); end
        n_cmp++; if (overlap != 0) begin n_bad++; $display("FAIL inv_done_err: got %0d want 0", overlap); end
    endtask

    initial begin
        set_dly(0, 0, 0, 0);
        last_res = '0;
        test_reset();
        test_basic();
        test_zero();
        test_timeout();
        test_ignore_start();
        test_reset_mid();
        test_timeout_race();
        test_random();
        test_invariants();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gcd_requester.md
GCD_REQUESTER -- requirements
Module: gcd_requester

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: operand/result width.
REQ-002 The block SHALL have parameter TIMEOUT, default 255: maximum cycles spent waiting in any handshake state.
REQ-003 The block SHALL have port clk, input, 1: the single clock; one clock, all flops on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 The block SHALL have port start, input, 1: one-cycle request to run a GCD job, honoured only in IDLE.
REQ-006 The block SHALL have port a_in, input, WIDTH: operand A, sampled when start is accepted.
REQ-007 The block SHALL have port b_in, input, WIDTH: operand B, sampled when start is accepted.
REQ-008 The block SHALL have port req, output, 1: 4-phase request to the GCD unit.
REQ-009 The block SHALL have port ack, input, 1: 4-phase acknowledge from the GCD unit, same clock domain, sampled directly.
REQ-010 The block SHALL have port data_out, output, WIDTH: operand bus to the GCD unit.
REQ-011 The block SHALL have port result_in, input, WIDTH: GCD unit result bus, valid while ack=1 after operand B.
REQ-012 The block SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1: one-cycle pulse when result is valid.
REQ-014 The block SHALL have port result, output, WIDTH: last captured GCD, held until the next done.
REQ-015 The block SHALL have port err, output, 1: one-cycle pulse on rejected or aborted job.

Function
REQ-016 The FSM SHALL have states IDLE, SEND_A, REL_A, SEND_B, REL_B, FLUSH; registered outputs, Moore style.
REQ-017 In IDLE, start=1 with a_in≠0 and b_in≠0 SHALL latch both operands and enter SEND_A next cycle.
REQ-018 In IDLE, start=1 with a_in=0 or b_in=0 SHALL pulse err next cycle and stay in IDLE, because the GCD unit never terminates on a zero operand.
REQ-019 start in any state other than IDLE SHALL be ignored, without queueing.
REQ-020 SEND_A SHALL drive req=1 and data_out=A, and go to REL_A on the first cycle ack=1.
REQ-021 REL_A SHALL drive req=0 and data_out=A, and go to SEND_B on the first cycle ack=0.
REQ-022 SEND_B SHALL drive req=1 and data_out=B, and on the first cycle ack=1 capture result_in into result and go to REL_B.
REQ-023 REL_B SHALL drive req=0, and on the first cycle ack=0 pulse done for one cycle and return to IDLE.
REQ-024 req SHALL change only on state entry and be glitch-free (flop output).
REQ-025 data_out SHALL be stable for the entire time req=1 and in the following release state.
REQ-026 A wait counter SHALL clear on every state change and increment each cycle in SEND_A, REL_A, SEND_B and REL_B.
REQ-027 When the wait counter reaches TIMEOUT, the FSM SHALL enter FLUSH.
REQ-028 FLUSH SHALL drive req=0, wait for ack=0 or a further TIMEOUT cycles, then pulse err and enter IDLE; result is unchanged.
REQ-029 If ack=1 in the same cycle the counter reaches TIMEOUT, the handshake transition SHALL win and no timeout occurs.
REQ-030 Minimum job latency SHALL be 4 ack edges; done SHALL assert no earlier than 1 cycle after ack falls in REL_B.
REQ-031 In IDLE, data_out SHALL be 0.
REQ-032 done and err SHALL never assert in the same cycle.

Reset
REQ-033 rst_n=0 SHALL immediately force IDLE with req=0, data_out=0, busy=0, done=0, err=0, result=0, counter=0, operands=0.
REQ-034 Reset asserted mid-job SHALL abandon the job with no done or err pulse.
REQ-035 After rst_n rises, the first start SHALL be accepted on the next rising edge.

Structure
REQ-036 A shared package gcd_pkg SHALL hold the state encoding (3 bits), the default WIDTH and the FN codes, shared with the GCD controller.
REQ-037 A single sub-module hs_timer SHALL implement the clearable saturating wait counter with a TIMEOUT compare output.

Verification
REQ-038 The bench SHALL apply A=12, B=18 with a responsive GCD model and require result=6, done pulse once, err=0, and exactly 4 ack edges.
REQ-039 The bench SHALL apply A=0, B=7 and require err pulse the cycle after start, req never rising, and busy=0 throughout.
REQ-040 The bench SHALL hold ack at 0 after SEND_A with TIMEOUT=10 and require FLUSH after 10 cycles, req=0, err pulse, and IDLE.
REQ-041 The bench SHALL pulse start during SEND_B of an A=35, B=21 job and require that it is ignored, result=7, and a single done.
REQ-042 The bench SHALL drop rst_n during REL_A and require req=0 immediately, no done or err, and a following A=9, B=6 job to give result=3.
REQ-043 The bench SHALL raise ack on exactly the TIMEOUT cycle in SEND_B and require normal completion with no err.
